// File: rtl/mips_pkg.sv
// Shared MIPS encoding definitions: instruction formats, field bit
// positions and common opcode/funct values.
package mips_pkg;

  // Field-bundle format selector.
  typedef enum logic [1:0] {
    FMT_R   = 2'b00,
    FMT_I   = 2'b01,
    FMT_J   = 2'b10,
    FMT_ILL = 2'b11
  } fmt_e;

  // Bit positions of each field inside a 32-bit instruction word.
  localparam int OP_HI    = 31;
  localparam int OP_LO    = 26;
  localparam int RS_HI    = 25;
  localparam int RS_LO    = 21;
  localparam int RT_HI    = 20;
  localparam int RT_LO    = 16;
  localparam int RD_HI    = 15;
  localparam int RD_LO    = 11;
  localparam int SH_HI    = 10;
  localparam int SH_LO    = 6;
  localparam int FN_HI    = 5;
  localparam int FN_LO    = 0;
  localparam int IMM16_HI = 15;
  localparam int IMM16_LO = 0;
  localparam int IMM26_HI = 25;
  localparam int IMM26_LO = 0;

  // Primary opcodes.
  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_ADDIU   = 6'h09;
  localparam logic [5:0] OP_ORI     = 6'h0D;
  localparam logic [5:0] OP_LUI     = 6'h0F;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_SW      = 6'h2B;

  // SPECIAL function codes.
  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_SLT  = 6'h2A;

  // True when the selector names a format that produces a word.
  function automatic logic fmt_is_legal(input logic [1:0] f);
    return f != FMT_ILL;
  endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// Field-bundle input handshake plus instruction-memory write port.
interface instr_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  fmt;
  logic [5:0]  opcode;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [4:0]  shamt;
  logic [5:0]  funct;
  logic [15:0] imm16;
  logic [25:0] imm26;
  logic        im_we;
  logic [31:0] im_addr;
  logic [31:0] im_wdata;
  logic        im_ready;
  logic [31:0] words_written;
  logic        err_fmt;

  // Encoder side.
  modport slave (
    input  in_valid, fmt, opcode, rs, rt, rd, shamt, funct, imm16, imm26, im_ready,
    output in_ready, im_we, im_addr, im_wdata, words_written, err_fmt
  );

  // Producer / memory side.
  modport master (
    output in_valid, fmt, opcode, rs, rt, rd, shamt, funct, imm16, imm26, im_ready,
    input  in_ready, im_we, im_addr, im_wdata, words_written, err_fmt
  );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers and a combinational head view.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  // Same index with differing wrap bits means every slot is occupied.
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem_q[rd_ptr_q[AW-1:0]];

  // Next pointer values.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
  end

  // Pointer registers; reset discards all contents.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage write; contents need no reset since pointers gate visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/instr_encoder.sv
// Packs decoded MIPS field bundles into instruction words and streams them
// through a small FIFO to sequential instruction-memory addresses.
module instr_encoder
  import mips_pkg::*;
#(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] BASE_ADDR = 32'h0000_3000
) (
  input  logic            clk,
  input  logic            reset,
  instr_encoder_if.slave  bus
);

  logic [31:0] word_d;
  logic        accept;
  logic        push;
  logic        pop;
  logic        fifo_full;
  logic        fifo_empty;
  logic [31:0] fifo_head;
  logic [31:0] im_addr_q, im_addr_d;
  logic [31:0] words_q, words_d;
  logic        err_fmt_q, err_fmt_d;

  // Ready depends only on registered occupancy, never on im_ready.
  assign accept = bus.in_valid && !fifo_full;
  assign push   = accept && fmt_is_legal(bus.fmt);
  assign pop    = !fifo_empty && bus.im_ready;

  // Packer: place only the fields the selected format uses.
  always_comb begin
    word_d = '0;
    word_d[OP_HI:OP_LO] = bus.opcode;
    case (fmt_e'(bus.fmt))
      FMT_R: begin
        word_d[RS_HI:RS_LO] = bus.rs;
        word_d[RT_HI:RT_LO] = bus.rt;
        word_d[RD_HI:RD_LO] = bus.rd;
        word_d[SH_HI:SH_LO] = bus.shamt;
        word_d[FN_HI:FN_LO] = bus.funct;
      end
      FMT_I: begin
        word_d[RS_HI:RS_LO]       = bus.rs;
        word_d[RT_HI:RT_LO]       = bus.rt;
        word_d[IMM16_HI:IMM16_LO] = bus.imm16;
      end
      FMT_J: begin
        word_d[IMM26_HI:IMM26_LO] = bus.imm26;
      end
      default: word_d = '0;
    endcase
  end

  sync_fifo #(
    .WIDTH (32),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (word_d),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (fifo_head)
  );

  // Address/count advance on each completed write; error flag follows a dropped bundle.
  always_comb begin
    im_addr_d = im_addr_q;
    words_d   = words_q;
    err_fmt_d = accept && !fmt_is_legal(bus.fmt);
    if (pop) begin
      im_addr_d = im_addr_q + 32'd4;
      words_d   = words_q + 32'd1;
    end
  end

  // Write-port state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      im_addr_q <= BASE_ADDR;
      words_q   <= '0;
      err_fmt_q <= 1'b0;
    end else begin
      im_addr_q <= im_addr_d;
      words_q   <= words_d;
      err_fmt_q <= err_fmt_d;
    end
  end

  assign bus.in_ready      = !fifo_full;
  assign bus.im_we         = !fifo_empty;
  // Stale storage is masked so the data bus reads zero while idle.
  assign bus.im_wdata      = fifo_empty ? 32'h0 : fifo_head;
  assign bus.im_addr       = im_addr_q;
  assign bus.words_written = words_q;
  assign bus.err_fmt       = err_fmt_q;

endmodule
